// File: rtl/adc_frontend_pkg.sv
// Shared constants for the ADC front end: frame reader state codes and the
// default SYNC header word.
package adc_frontend_pkg;

    typedef logic [1:0] frame_rd_state_e;

    localparam frame_rd_state_e ST_IDLE    = 2'd0;
    localparam frame_rd_state_e ST_HDR     = 2'd1;
    localparam frame_rd_state_e ST_SEQ     = 2'd2;
    localparam frame_rd_state_e ST_PAYLOAD = 2'd3;

    localparam logic [15:0] DEFAULT_SYNC_WORD = 16'hA5C3;

endpackage

// File: rtl/frame_skid_buf.sv
// Two-entry FIFO holding {data, sof, last} words between the frame reader's
// producers (header/sequence/FIFO returns) and the output stream.
module frame_skid_buf #(
    parameter int W = 18
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [1:0]   occ,
    output logic [W-1:0] head
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            occ <= occ + 2'(push) - 2'(pop);
        end
    end

    // NOTE: storage is left unreset; the top gates every output field with
    // m_valid, so stale entries are never observable.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/adc_frame_reader.sv
// Drains the ADC CDC FIFO and emits SYNC / sequence / payload frames on a
// ready/valid stream, with credit-based flow control into a 2-entry buffer.
module adc_frame_reader
    import adc_frontend_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter int               FRAME_LEN = 256,
    parameter logic [WIDTH-1:0] SYNC_WORD = WIDTH'(DEFAULT_SYNC_WORD)
) (
    input  logic             rd_clk,
    input  logic             rd_rst,
    input  logic             enable,
    output logic             fifo_rd_en,
    input  logic [WIDTH-1:0] fifo_rd_data,
    input  logic             fifo_rd_valid,
    input  logic             fifo_rd_empty,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_sof,
    output logic             m_last,
    output logic [15:0]      frame_cnt,
    output logic             proto_err
);

    localparam int CW = $clog2(FRAME_LEN + 1);

    frame_rd_state_e  state;
    logic [CW-1:0]    req_cnt;
    logic             inflight;
    logic             last_tag;
    logic [WIDTH-1:0] seq;

    logic [1:0]       occ;
    logic [WIDTH+1:0] head;
    logic [WIDTH+1:0] push_word;
    logic             push;
    logic             pop;
    logic [2:0]       fill_next;
    logic             credit;
    logic             last_read;
    logic             hdr_push;
    logic             seq_push;
    logic             ret_push;

    assign m_valid = (occ != 2'd0);
    assign pop     = m_valid & m_ready;
    assign m_data  = m_valid ? head[WIDTH+1:2] : '0;
    assign m_sof   = m_valid & head[1];
    assign m_last  = m_valid & head[0];

    // An issued read owns a buffer slot until its data returns next cycle.
    assign fill_next = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    assign credit    = (fill_next < 3'd2);

    assign last_read  = (req_cnt == CW'(FRAME_LEN - 1));
    assign fifo_rd_en = !rd_rst && (state == ST_PAYLOAD) && credit &&
                        !fifo_rd_empty && (req_cnt < CW'(FRAME_LEN));
    assign hdr_push   = (state == ST_HDR) && credit && !inflight;
    assign seq_push   = (state == ST_SEQ) && credit;
    assign ret_push   = fifo_rd_valid && inflight;
    assign push       = ret_push | hdr_push | seq_push;

    // NOTE: every path through a combinational block assigns a default
    // first, so no latch can be inferred.
    always_comb begin
        push_word = '0;
        if (ret_push)      push_word = {fifo_rd_data, 1'b0, last_tag};
        else if (hdr_push) push_word = {SYNC_WORD, 1'b1, 1'b0};
        else if (seq_push) push_word = {seq, 1'b0, 1'b0};
    end

    frame_skid_buf #(.W(WIDTH + 2)) u_buf (
        .clk       (rd_clk),
        .rst       (rd_rst),
        .push      (push),
        .push_data (push_word),
        .pop       (pop),
        .occ       (occ),
        .head      (head)
    );

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            state     <= ST_IDLE;
            req_cnt   <= '0;
            inflight  <= 1'b0;
            last_tag  <= 1'b0;
            seq       <= '0;
            frame_cnt <= '0;
            proto_err <= 1'b0;
        end else begin
            inflight <= fifo_rd_en;
            if (fifo_rd_en)                 last_tag  <= last_read;
            if (fifo_rd_valid && !inflight) proto_err <= 1'b1;
            if (pop && m_last)              frame_cnt <= frame_cnt + 16'd1;

            case (state)
                ST_IDLE: if (enable) state <= ST_HDR;
                ST_HDR:  if (hdr_push) state <= ST_SEQ;
                ST_SEQ: begin
                    if (seq_push) begin
                        seq   <= seq + WIDTH'(1);
                        state <= ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (fifo_rd_en) begin
                        if (last_read) begin
                            req_cnt <= '0;
                            state   <= enable ? ST_HDR : ST_IDLE;
                        end else begin
                            req_cnt <= req_cnt + CW'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_frame_reader.sv
// Self-checking bench for adc_frame_reader: FIFO model, randomized samples and
// a frame-level scoreboard of expected output words.
module tb_adc_frame_reader;
    import adc_frontend_pkg::*;

    localparam int          WIDTH = 16;
    localparam int          FL    = 4;
    localparam logic [15:0] SYNC  = 16'hA5C3;

    typedef struct packed {
        logic [15:0] data;
        logic        sof;
        logic        last;
    } word_t;

    logic        rd_clk = 1'b0;
    logic        rd_rst = 1'b1;
    logic        enable = 1'b0;
    logic        fifo_rd_en;
    logic [15:0] fifo_rd_data;
    logic        fifo_rd_valid;
    logic        fifo_rd_empty = 1'b1;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_sof;
    logic        m_last;
    logic [15:0] frame_cnt;
    logic        proto_err;

    always #5 rd_clk = ~rd_clk;

    adc_frame_reader #(.WIDTH(WIDTH), .FRAME_LEN(FL), .SYNC_WORD(SYNC)) dut (
        .rd_clk        (rd_clk),
        .rd_rst        (rd_rst),
        .enable        (enable),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_rd_data  (fifo_rd_data),
        .fifo_rd_valid (fifo_rd_valid),
        .fifo_rd_empty (fifo_rd_empty),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_sof         (m_sof),
        .m_last        (m_last),
        .frame_cnt     (frame_cnt),
        .proto_err     (proto_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // FIFO model: data and valid return one cycle after an accepted read.
    logic [15:0] fifo_q[$];
    logic        ret_valid   = 1'b0;
    logic [15:0] ret_data    = '0;
    logic        force_valid = 1'b0;
    int          reads_seen  = 0;

    always @(posedge rd_clk) begin
        if (fifo_rd_en && fifo_q.size() > 0) begin
            ret_data   <= fifo_q.pop_front();
            ret_valid  <= 1'b1;
            reads_seen <= reads_seen + 1;
        end else begin
            ret_valid <= 1'b0;
        end
        fifo_rd_empty <= (fifo_q.size() == 0);
    end

    assign fifo_rd_valid = ret_valid | force_valid;
    assign fifo_rd_data  = force_valid ? 16'hDEAD : ret_data;

    // Downstream ready: 0 = always, 1 = toggle, 2 = random, 3 = held low.
    int ready_mode = 0;
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge rd_clk);
            #1;
            case (ready_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = ~m_ready;
                2:       m_ready = 1'($urandom_range(0, 1));
                default: m_ready = 1'b0;
            endcase
        end
    end

    // Scoreboard: expected words, completed-frame count, stall stability.
    word_t       exp_q[$];
    int          exp_frames = 0;
    logic [15:0] exp_seq    = '0;
    logic        held       = 1'b0;
    word_t       held_w;

    always @(negedge rd_clk) begin
        if (rd_rst) begin
            exp_q.delete();
            exp_frames = 0;
            held       = 1'b0;
        end else begin
            if (held)
                check("stall_hold", {13'd0, m_valid, m_data, m_sof, m_last}, {13'd0, 1'b1, held_w});
            if (fifo_rd_empty)
                check("rd_en_when_empty", 32'(fifo_rd_en), 32'd0);
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", {14'd0, m_data, m_sof, m_last}, 32'hFFFF_FFFF);
                end else begin
                    word_t w;
                    w = exp_q.pop_front();
                    check("beat", {14'd0, m_data, m_sof, m_last}, {14'd0, w});
                    if (w.last) exp_frames++;
                end
            end
            held   = m_valid && !m_ready;
            held_w = {m_data, m_sof, m_last};
        end
    end

    task automatic expect_frame(input logic [15:0] s[$], input int first);
        exp_q.push_back({SYNC, 1'b1, 1'b0});
        exp_q.push_back({exp_seq, 1'b0, 1'b0});
        exp_seq++;
        for (int k = 0; k < FL; k++)
            exp_q.push_back({s[first + k], 1'b0, (k == FL - 1)});
    endtask

    task automatic wait_reads(input int target);
        int n = 0;
        while (reads_seen < target && n < 300) begin
            @(posedge rd_clk);
            #1;
            n++;
        end
        if (reads_seen < target) check("read_timeout", 32'(reads_seen), 32'(target));
    endtask

    // Runs nfr frames; enable drops while the second read of the last frame
    // is issued. If first_load is short, the rest arrives after gap cycles.
    task automatic do_frames(input int nfr, input int first_load, input int gap, input bit counting);
        logic [15:0] s[$];
        int base;
        int n;
        for (int i = 0; i < nfr * FL; i++)
            s.push_back(counting ? 16'(i + 1) : 16'($urandom));
        for (int f = 0; f < nfr; f++) expect_frame(s, f * FL);
        base = reads_seen;
        @(posedge rd_clk);
        #1;
        for (int i = 0; i < first_load; i++) fifo_q.push_back(s[i]);
        enable = 1'b1;
        wait_reads(base + (nfr - 1) * FL + 2);
        enable = 1'b0;
        if (first_load < s.size()) begin
            repeat (gap) @(posedge rd_clk);
            #1;
            check("stall_reads", 32'(reads_seen - base), 32'(first_load));
            for (int i = first_load; i < s.size(); i++) fifo_q.push_back(s[i]);
        end
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge rd_clk);
            #1;
            n++;
        end
        check("drain_left", 32'(exp_q.size()), 32'd0);
        repeat (5) @(posedge rd_clk);
        #1;
        check("idle_state", 32'(dut.state), 32'(ST_IDLE));
        check("idle_valid", 32'(m_valid), 32'd0);
        check("frame_cnt", 32'(frame_cnt), 32'(exp_frames));
    endtask

    task automatic pulse_reset();
        @(posedge rd_clk);
        #1;
        rd_rst  = 1'b1;
        enable  = 1'b0;
        exp_seq = '0;
        fifo_q.delete();
        @(posedge rd_clk);
        #1;
        rd_rst = 1'b0;
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rst_sof_last", {30'd0, m_sof, m_last}, 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    initial begin
        logic [15:0] s[$];
        int n;

        // Reset state
        repeat (3) @(posedge rd_clk);
        #1;
        check("reset_m_valid", 32'(m_valid), 32'd0);
        check("reset_rd_en", 32'(fifo_rd_en), 32'd0);
        check("reset_sof_last", {30'd0, m_sof, m_last}, 32'd0);
        check("reset_m_data", 32'(m_data), 32'd0);
        check("reset_frame_cnt", 32'(frame_cnt), 32'd0);
        check("reset_proto_err", 32'(proto_err), 32'd0);
        check("reset_state", 32'(dut.state), 32'(ST_IDLE));
        rd_rst = 1'b0;

        // Two back-to-back frames of samples 1..8
        ready_mode = 0;
        do_frames(2, 2 * FL, 0, 1'b1);

        // Toggling ready during payload
        ready_mode = 1;
        do_frames(2, 2 * FL, 0, 1'b0);

        // FIFO runs empty after 2 samples, refilled 20 cycles later
        ready_mode = 0;
        do_frames(1, 2, 20, 1'b0);

        // Enable dropped during sample 2, random ready
        ready_mode = 2;
        do_frames(1, FL, 0, 1'b0);
        check("proto_err_clean", 32'(proto_err), 32'd0);

        // Reset while a FIFO read is in flight
        ready_mode = 0;
        for (int i = 0; i < FL; i++) s.push_back(16'($urandom));
        expect_frame(s, 0);
        @(posedge rd_clk);
        #1;
        for (int i = 0; i < FL; i++) fifo_q.push_back(s[i]);
        enable = 1'b1;
        n = 0;
        while (!fifo_rd_en && n < 50) begin
            @(negedge rd_clk);
            n++;
        end
        check("saw_read", 32'(fifo_rd_en), 32'd1);
        pulse_reset();

        // Reset while output stalled with m_valid=1
        ready_mode = 3;
        repeat (2) @(posedge rd_clk);
        #1;
        expect_frame(s, 0);
        for (int i = 0; i < FL; i++) fifo_q.push_back(s[i]);
        enable = 1'b1;
        n = 0;
        while (!m_valid && n < 50) begin
            @(negedge rd_clk);
            n++;
        end
        check("saw_valid_stalled", 32'(m_valid & ~m_ready), 32'd1);
        pulse_reset();

        // First frame after reset restarts at seq 0
        ready_mode = 0;
        do_frames(1, FL, 0, 1'b0);

        // Spurious return strobe with nothing in flight
        check("proto_err_before", 32'(proto_err), 32'd0);
        @(posedge rd_clk);
        #1;
        force_valid = 1'b1;
        @(posedge rd_clk);
        #1;
        force_valid = 1'b0;
        check("proto_err_set", 32'(proto_err), 32'd1);
        repeat (10) @(posedge rd_clk);
        #1;
        check("proto_err_sticky", 32'(proto_err), 32'd1);
        check("proto_no_output", 32'(m_valid), 32'd0);
        check("proto_frame_cnt", 32'(frame_cnt), 32'(exp_frames));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
